// File: rtl/pi_ctrl_seq.sv
// Control sequencer for the shared 16-bit PI datapath ALU: starts an A2D conversion, steps the
// ALU selects/op flags through one PI update and captures each ALU result into its register.
module pi_ctrl_seq #(
    parameter logic [2:0]  CHNL        = 3'd0,
    parameter int unsigned MULT_CYCLES = 2,
    parameter int unsigned CNV_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go_i,
    input  logic        cnv_cmplt_i,
    input  logic [15:0] dst_i,
    output logic        strt_cnv_o,
    output logic [2:0]  chnnl_o,
    output logic [2:0]  src0sel_o,
    output logic [2:0]  src1sel_o,
    output logic        multiply_o,
    output logic        sub_o,
    output logic        mult2_o,
    output logic        mult4_o,
    output logic        saturate_o,
    output logic [11:0] error_o,
    output logic [11:0] intgrl_o,
    output logic [11:0] icomp_o,
    output logic [15:0] pcomp_o,
    output logic [15:0] accum_o,
    output logic [11:0] duty_o,
    output logic        done_o,
    output logic        cnv_err_o
);

    localparam int unsigned StepW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
    localparam logic [StepW-1:0] StepLast = StepW'(MULT_CYCLES - 1);
    localparam logic [7:0] TmoLast = 8'(CNV_TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle, StCnv, StErr, StIntg, StIcmp, StPcmp, StAcc, StOut, StDone
    } state_e;

    state_e           state_q;
    logic [7:0]       tmo_q;
    logic [StepW-1:0] step_q;
    logic [1:0]       int_dec_q;
    logic [11:0]      error_q, intgrl_q, icomp_q, duty_q;
    logic [15:0]      pcomp_q, accum_q;
    logic             strt_cnv_q, done_q, cnv_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tmo_q      <= '0;
            step_q     <= '0;
            int_dec_q  <= '0;
            error_q    <= '0;
            intgrl_q   <= '0;
            icomp_q    <= '0;
            pcomp_q    <= '0;
            accum_q    <= '0;
            duty_q     <= '0;
            strt_cnv_q <= 1'b0;
            done_q     <= 1'b0;
            cnv_err_q  <= 1'b0;
        end else begin
            strt_cnv_q <= 1'b0;
            done_q     <= 1'b0;
            cnv_err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (go_i) begin
                        strt_cnv_q <= 1'b1;
                        tmo_q      <= '0;
                        state_q    <= StCnv;
                    end
                end
                StCnv: begin
                    if (cnv_cmplt_i) begin
                        state_q <= StErr;
                    end else if (tmo_q == TmoLast) begin
                        cnv_err_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                StErr: begin
                    error_q <= dst_i[11:0];
                    state_q <= StIntg;
                end
                StIntg: begin
                    // Integrator only updates on every fourth loop.
                    if (int_dec_q == 2'b11) intgrl_q <= dst_i[11:0];
                    step_q  <= '0;
                    state_q <= StIcmp;
                end
                StIcmp: begin
                    if (step_q == StepLast) begin
                        icomp_q <= dst_i[11:0];
                        step_q  <= '0;
                        state_q <= StPcmp;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                StPcmp: begin
                    if (step_q == StepLast) begin
                        pcomp_q <= dst_i;
                        step_q  <= '0;
                        state_q <= StAcc;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                StAcc: begin
                    accum_q <= dst_i;
                    state_q <= StOut;
                end
                StOut: begin
                    duty_q  <= dst_i[11:0];
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    int_dec_q <= int_dec_q + 2'd1;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        src0sel_o  = 3'd0;
        src1sel_o  = 3'd0;
        multiply_o = 1'b0;
        sub_o      = 1'b0;
        saturate_o = 1'b0;
        unique case (state_q)
            StErr: begin
                src1sel_o  = 3'd4;
                src0sel_o  = 3'd0;
                sub_o      = 1'b1;
                saturate_o = 1'b1;
            end
            StIntg: begin
                src1sel_o  = 3'd3;
                src0sel_o  = 3'd1;
                saturate_o = 1'b1;
            end
            StIcmp: begin
                src1sel_o  = 3'd1;
                src0sel_o  = 3'd1;
                multiply_o = 1'b1;
            end
            StPcmp: begin
                src1sel_o  = 3'd2;
                src0sel_o  = 3'd4;
                multiply_o = 1'b1;
            end
            StAcc: begin
                src1sel_o = 3'd4;
                src0sel_o = 3'd3;
                sub_o     = 1'b1;
            end
            StOut: begin
                src1sel_o  = 3'd0;
                src0sel_o  = 3'd2;
                sub_o      = 1'b1;
                saturate_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign mult2_o    = 1'b0;
    assign mult4_o    = 1'b0;
    assign chnnl_o    = CHNL;
    assign strt_cnv_o = strt_cnv_q;
    assign done_o     = done_q;
    assign cnv_err_o  = cnv_err_q;
    assign error_o    = error_q;
    assign intgrl_o   = intgrl_q;
    assign icomp_o    = icomp_q;
    assign pcomp_o    = pcomp_q;
    assign accum_o    = accum_q;
    assign duty_o     = duty_q;

endmodule

// File: tb/tb_pi_ctrl_seq.sv
// Bench for pi_ctrl_seq: behavioural ALU drives dst, PI-equation reference model predicts
// every captured register after each loop.
module tb_pi_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go, cnv_cmplt;
    logic [15:0] dst;
    logic        strt_cnv;
    logic [2:0]  chnnl, src0sel, src1sel;
    logic        multiply, sub, mult2, mult4, saturate;
    logic [11:0] error, intgrl, icomp, duty;
    logic [15:0] pcomp, accum;
    logic        done, cnv_err;

    // ALU-side operands owned by the environment
    logic [11:0] a2d, fwd;
    logic [15:0] pterm, iterm;

    // reference model state
    logic [11:0] m_err, m_intg, m_icomp, m_duty;
    logic [15:0] m_pcomp, m_accum;
    int          m_loops;

    int tests = 0;
    int fails = 0;
    int alu_s0, alu_s1, alu_r;

    pi_ctrl_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .go_i        (go),
        .cnv_cmplt_i (cnv_cmplt),
        .dst_i       (dst),
        .strt_cnv_o  (strt_cnv),
        .chnnl_o     (chnnl),
        .src0sel_o   (src0sel),
        .src1sel_o   (src1sel),
        .multiply_o  (multiply),
        .sub_o       (sub),
        .mult2_o     (mult2),
        .mult4_o     (mult4),
        .saturate_o  (saturate),
        .error_o     (error),
        .intgrl_o    (intgrl),
        .icomp_o     (icomp),
        .pcomp_o     (pcomp),
        .accum_o     (accum),
        .duty_o      (duty),
        .done_o      (done),
        .cnv_err_o   (cnv_err)
    );

    always #5 clk = ~clk;

    function automatic int sx12(input logic [11:0] v);
        return int'(signed'(v));
    endfunction

    function automatic int sx16(input logic [15:0] v);
        return int'(signed'(v));
    endfunction

    function automatic int sat12(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic int mul(input int a, input int b);
        return (a * b) >>> 12;
    endfunction

    // Behavioural shared ALU
    always_comb begin
        alu_s0 = 0;
        alu_s1 = 0;
        alu_r  = 0;
        case (src0sel)
            3'd0: alu_s0 = int'(a2d);
            3'd1: alu_s0 = sx12(intgrl);
            3'd2: alu_s0 = sx12(icomp);
            3'd3: alu_s0 = sx16(pcomp);
            3'd4: alu_s0 = sx16(pterm);
            default: alu_s0 = 0;
        endcase
        case (src1sel)
            3'd0: alu_s1 = sx16(accum);
            3'd1: alu_s1 = sx16(iterm);
            3'd2: alu_s1 = sx12(error);
            3'd3: alu_s1 = sx12(error) >>> 4;
            3'd4: alu_s1 = int'(fwd);
            default: alu_s1 = 0;
        endcase
        if (multiply) alu_r = mul(alu_s1, alu_s0);
        else if (sub) alu_r = alu_s1 - alu_s0;
        else alu_r = alu_s1 + alu_s0;
        if (saturate) alu_r = sat12(alu_r);
    end
    assign dst = alu_r[15:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One PI update from the control-law equations
    task automatic model_loop();
        int e, ig, ic, pc, ac;
        e = sat12(int'(fwd) - int'(a2d));
        ig = sx12(m_intg);
        if (m_loops % 4 == 3) ig = sat12(ig + (e >>> 4));
        ic = mul(sx16(iterm), ig);
        pc = mul(e, sx16(pterm));
        ac = int'(fwd) - sx16(16'(pc));
        m_err   = 12'(e);
        m_intg  = 12'(ig);
        m_icomp = 12'(ic);
        m_pcomp = 16'(pc);
        m_accum = 16'(ac);
        m_duty  = 12'(sat12(sx16(m_accum) - sx12(m_icomp)));
        m_loops++;
    endtask

    task automatic model_reset();
        m_err = '0; m_intg = '0; m_icomp = '0; m_duty = '0;
        m_pcomp = '0; m_accum = '0; m_loops = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_error"}, 32'(error), 32'(m_err));
        chk({tag, "_intgrl"}, 32'(intgrl), 32'(m_intg));
        chk({tag, "_icomp"}, 32'(icomp), 32'(m_icomp));
        chk({tag, "_pcomp"}, 32'(pcomp), 32'(m_pcomp));
        chk({tag, "_accum"}, 32'(accum), 32'(m_accum));
        chk({tag, "_duty"}, 32'(duty), 32'(m_duty));
    endtask

    // Starts just after a negedge and ends just after a negedge with the FSM in IDLE.
    task automatic run_loop(input string tag, input int dly, input bit poke);
        int n, cnt;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk({tag, "_strt_cnv"}, 32'(strt_cnv), 32'd1);
        repeat (dly) @(negedge clk);
        cnv_cmplt = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            cnv_cmplt = 1'b0;
            n++;
            go = poke && multiply && (src1sel == 3'd1);
        end while (!done && n < 40);
        chk({tag, "_latency"}, 32'(n), 32'd9);
        model_loop();
        check_regs(tag);
        if (poke) begin
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
            cnt = 0;
            repeat (8) begin
                if (strt_cnv || done) cnt++;
                @(negedge clk);
            end
            chk({tag, "_ignored_go"}, 32'(cnt), 32'd0);
        end else begin
            @(negedge clk);
            chk({tag, "_done_width"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dn;
        rst_n = 1'b0; go = 1'b0; cnv_cmplt = 1'b0;
        a2d = 12'h300; fwd = 12'h400; pterm = 16'h1000; iterm = 16'h0100;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        check_regs("rst");
        chk("rst_strt_cnv", 32'(strt_cnv), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cnv_err", 32'(cnv_err), 32'd0);
        chk("rst_selects", 32'({src0sel, src1sel}), 32'd0);
        chk("rst_flags", 32'({multiply, sub, mult2, mult4, saturate}), 32'd0);
        chk("chnnl", 32'(chnnl), 32'd0);

        // first loop, literal expectations
        run_loop("t1", 1, 1'b0);
        chk("t1_error_lit", 32'(error), 32'h100);
        chk("t1_pcomp_lit", 32'(pcomp), 32'h100);
        chk("t1_accum_lit", 32'(accum), 32'h300);
        chk("t1_duty_lit", 32'(duty), 32'h300);

        // saturation
        fwd = 12'hFFF; a2d = 12'h000;
        run_loop("t2", 0, 1'b0);
        chk("t2_error_sat", 32'(error), 32'h7FF);
        chk("t2_duty_sat", 32'(duty), 32'h7FF);

        // integrator decimation from a fresh reset
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        fwd = 12'h400; a2d = 12'h300;
        for (int i = 1; i <= 8; i++) begin
            run_loop("t3", 0, 1'b0);
            if (i == 3) chk("t3_intgrl_l3", 32'(intgrl), 32'h000);
            if (i == 4) chk("t3_intgrl_l4", 32'(intgrl), 32'h010);
            if (i == 8) chk("t3_intgrl_l8", 32'(intgrl), 32'h020);
        end

        // conversion timeout
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n = 0; dn = 0;
        while (!cnv_err && n < 400) begin
            @(negedge clk);
            n++;
            if (done) dn++;
        end
        chk("t4_timeout_cycles", 32'(n), 32'd255);
        chk("t4_no_done", 32'(dn), 32'd0);
        @(negedge clk);
        chk("t4_err_width", 32'(cnv_err), 32'd0);
        check_regs("t4");
        run_loop("t4_after", 2, 1'b0);

        // go pulses during ICMP and DONE are dropped
        fwd = 12'h250; a2d = 12'h1C0;
        run_loop("t6", 1, 1'b1);
        run_loop("t6_next", 0, 1'b0);

        // asynchronous reset in PCMP
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cnv_cmplt = 1'b1;
        @(negedge clk);
        cnv_cmplt = 1'b0;
        n = 0;
        while (!(multiply && src0sel == 3'd4) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_pcmp", 32'(multiply && src0sel == 3'd4), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("t5_async");
        chk("t5_selects", 32'({src0sel, src1sel}), 32'd0);
        chk("t5_flags", 32'({multiply, sub, saturate, done, strt_cnv, cnv_err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fwd = 12'h400; a2d = 12'h300;
        run_loop("t5_clean", 0, 1'b0);

        // randomized loops; int_dec restarted at reset above
        for (int i = 0; i < 12; i++) begin
            fwd   = 12'($urandom);
            a2d   = 12'($urandom);
            pterm = 16'($urandom);
            iterm = 16'($urandom);
            run_loop("rnd", int'($urandom_range(0, 3)), 1'b0);
            chk("rnd_mult24", 32'({mult2, mult4}), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
